// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: access size encoding and arbiter FSM states.
// No logic, no latency.
// No flow control.
package mem_port_arbiter_pkg;

    // Width of the consecutive-data-grant counter (limit range 1..15)
    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        MEM_BYTE     = 2'd0,
        MEM_HALFWORD = 2'd1,
        MEM_WORD     = 2'd2
    } memory_mask_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY_IF,
        ARB_BUSY_D,
        ARB_ERR_D
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// External memory bus: one request at a time, held until the memory signals ready.
// Read data returns combinationally with ready.
// The arbiter keeps the request asserted and stable until ready is seen.
interface mem_port_arbiter_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    // Arbiter side: drives the request, receives completion
    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    // Memory side
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter_lane_align.sv
// Byte-lane steering: store byte enables and lane replication, misalignment detect, load align/extend.
// Purely combinational, zero latency.
// No flow control.
module mem_port_arbiter_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]   off,
    input  memory_mask_t mask,
    input  logic         sign_ext,
    input  logic [31:0]  wdata,
    input  logic [31:0]  rdata,
    output logic [3:0]   be,
    output logic [31:0]  wdata_lane,
    output logic         misaligned,
    output logic [31:0]  rdata_aligned
);
    logic [31:0] shifted;

    // Lane selection and load extension by access size
    always_comb begin
        shifted       = rdata >> {off, 3'b000};
        be            = 4'b1111;
        wdata_lane    = wdata;
        misaligned    = 1'b0;
        rdata_aligned = rdata;
        case (mask)
            MEM_BYTE: begin
                be            = 4'b0001 << off;
                wdata_lane    = {4{wdata[7:0]}};
                rdata_aligned = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            end
            MEM_HALFWORD: begin
                be            = 4'b0011 << off;
                wdata_lane    = {2{wdata[15:0]}};
                misaligned    = off[0];
                rdata_aligned = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                misaligned    = |off;
            end
        endcase
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; data has priority, fetch gets a turn after a streak.
// Grant registered one cycle after request; ack is same-cycle with mem_ready; misaligned data acks at N+1.
// Requesters hold their request until ack; mem_req is held until mem_ready.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [31:0]          if_addr,
    output logic                 if_ack,
    output logic [31:0]          if_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [31:0]          d_addr,
    input  logic [31:0]          d_wdata,
    input  memory_mask_t         d_mask,
    input  logic                 d_sign_ext,
    output logic                 d_ack,
    output logic                 d_err,
    output logic [31:0]          d_rdata,
    mem_port_arbiter_if.master   mem
);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    arb_state_t          state;
    logic [STREAK_W-1:0] streak;
    logic [1:0]          lat_off;
    memory_mask_t        lat_mask;
    logic                lat_sign;

    logic                grant_d;
    logic [1:0]          sel_off;
    memory_mask_t        sel_mask;
    logic                sel_sign;
    logic [3:0]          lane_be;
    logic [31:0]         lane_wdata;
    logic                lane_misaligned;
    logic [31:0]         lane_rdata;
    logic                if_addr_unused;

    // Fetch is always word aligned; the low address bits carry no information
    assign if_addr_unused = ^if_addr[1:0];

    // Data wins unless it has already taken STREAK_MAX grants in a row past a waiting fetch
    assign grant_d = d_req & (~if_req | (streak < STREAK_MAX));

    // While idle the lane logic looks at the live request; afterwards at the latched copy
    assign sel_off  = (state == ARB_IDLE) ? d_addr[1:0] : lat_off;
    assign sel_mask = (state == ARB_IDLE) ? d_mask      : lat_mask;
    assign sel_sign = (state == ARB_IDLE) ? d_sign_ext  : lat_sign;

    mem_port_arbiter_lane_align u_lane (
        .off           (sel_off),
        .mask          (sel_mask),
        .sign_ext      (sel_sign),
        .wdata         (d_wdata),
        .rdata         (mem.mem_rdata),
        .be            (lane_be),
        .wdata_lane    (lane_wdata),
        .misaligned    (lane_misaligned),
        .rdata_aligned (lane_rdata)
    );

    // Completion signals follow mem_ready in the same cycle
    assign if_ack   = (state == ARB_BUSY_IF) & mem.mem_ready;
    assign d_ack    = ((state == ARB_BUSY_D) & mem.mem_ready) | (state == ARB_ERR_D);
    assign d_err    = (state == ARB_ERR_D);
    assign if_rdata = mem.mem_rdata;
    assign d_rdata  = (state == ARB_BUSY_D) ? lane_rdata : 32'd0;

    // Arbitration FSM, request latching, memory bus registers and streak counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ARB_IDLE;
            streak        <= '0;
            lat_off       <= 2'b00;
            lat_mask      <= MEM_BYTE;
            lat_sign      <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'd0;
            mem.mem_be    <= 4'd0;
            mem.mem_wdata <= 32'd0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_d) begin
                        lat_off  <= d_addr[1:0];
                        lat_mask <= d_mask;
                        lat_sign <= d_sign_ext;
                        streak   <= if_req ? streak + 1'b1 : '0;
                        if (lane_misaligned) begin
                            state <= ARB_ERR_D;
                        end else begin
                            state         <= ARB_BUSY_D;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= d_we;
                            mem.mem_addr  <= {d_addr[31:2], 2'b00};
                            mem.mem_be    <= lane_be;
                            mem.mem_wdata <= lane_wdata;
                        end
                    end else if (if_req) begin
                        state        <= ARB_BUSY_IF;
                        streak       <= '0;
                        mem.mem_req  <= 1'b1;
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= {if_addr[31:2], 2'b00};
                        mem.mem_be   <= 4'b1111;
                    end
                end
                ARB_BUSY_IF, ARB_BUSY_D: begin
                    if (mem.mem_ready) begin
                        state       <= ARB_IDLE;
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                    end
                end
                ARB_ERR_D: state <= ARB_IDLE;
                default:   state <= ARB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed traffic against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int MAX_STREAK = 4;

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        memory_mask_t mask;
        logic         sign;
    } dreq_t;

    typedef enum {M_IDLE, M_IF, M_D, M_ERR} mstate_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         if_req = 1'b0;
    logic [31:0]  if_addr = 32'd0;
    logic         if_ack;
    logic [31:0]  if_rdata;
    logic         d_req = 1'b0;
    logic         d_we = 1'b0;
    logic [31:0]  d_addr = 32'd0;
    logic [31:0]  d_wdata = 32'd0;
    memory_mask_t d_mask = MEM_WORD;
    logic         d_sign_ext = 1'b0;
    logic         d_ack;
    logic         d_err;
    logic [31:0]  d_rdata;

    mem_port_arbiter_if mem_bus();

    mem_port_arbiter #(.MAX_DATA_STREAK(MAX_STREAK)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ack     (if_ack),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_mask     (d_mask),
        .d_sign_ext (d_sign_ext),
        .d_ack      (d_ack),
        .d_err      (d_err),
        .d_rdata    (d_rdata),
        .mem        (mem_bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // ---------------- reference model helpers ----------------
    function automatic int msize(input memory_mask_t m);
        case (m)
            MEM_BYTE:     return 1;
            MEM_HALFWORD: return 2;
            default:      return 4;
        endcase
    endfunction

    function automatic logic is_misaligned(input dreq_t r);
        return (int'(r.addr[1:0]) % msize(r.mask)) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input dreq_t r);
        logic [3:0] b = 4'd0;
        for (int i = 0; i < msize(r.mask); i++) b[int'(r.addr[1:0]) + i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] exp_wdata(input dreq_t r);
        logic [31:0] v = 32'd0;
        for (int lane = 0; lane < 4; lane++)
            v[8*lane +: 8] = r.wdata[8*(lane % msize(r.mask)) +: 8];
        return v;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input dreq_t r);
        logic [31:0] v = 32'd0;
        int sz = msize(r.mask);
        int off = int'(r.addr[1:0]);
        for (int i = 0; i < sz; i++) v[8*i +: 8] = w[8*(off + i) +: 8];
        if (r.sign && sz < 4 && v[8*sz - 1])
            for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    // ---------------- model state ----------------
    logic [31:0] fq[$];
    dreq_t       dq[$];
    logic [31:0] if_rdata_log[$];
    logic [31:0] d_rdata_log[$];
    logic        grant_log[$];

    mstate_t     m_state = M_IDLE;
    int          streak_m = 0;
    int          wait_cnt = 0;
    int          delay_knob = -1;
    logic        fixed_en = 1'b0;
    logic [31:0] fixed_val = 32'd0;
    logic        if_pend = 1'b0;
    logic        d_pend = 1'b0;
    logic [31:0] cur_if = 32'd0;
    dreq_t       cur_d;
    logic [3:0]  last_st_be = 4'd0;
    logic [31:0] last_st_wdata = 32'd0;
    logic [31:0] last_st_addr = 32'd0;

    task automatic run_traffic(input int budget);
        int          cyc = 0;
        logic        rdy;
        logic [31:0] rd;
        logic        done = 1'b0;
        mstate_t     nxt;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            // registered bus outputs reflect the grant in progress
            if (m_state == M_IF) begin
                chk("if_mem_req", mem_bus.mem_req, 1);
                chk("if_mem_addr", mem_bus.mem_addr, cur_if & 32'hFFFF_FFFC);
                chk("if_mem_be", mem_bus.mem_be, 4'hF);
                chk("if_mem_we", mem_bus.mem_we, 0);
            end else if (m_state == M_D) begin
                chk("d_mem_req", mem_bus.mem_req, 1);
                chk("d_mem_addr", mem_bus.mem_addr, cur_d.addr & 32'hFFFF_FFFC);
                chk("d_mem_be", mem_bus.mem_be, exp_be(cur_d));
                chk("d_mem_we", mem_bus.mem_we, cur_d.we);
                if (cur_d.we) begin
                    chk("d_mem_wdata", mem_bus.mem_wdata, exp_wdata(cur_d));
                    last_st_be    = mem_bus.mem_be;
                    last_st_wdata = mem_bus.mem_wdata;
                    last_st_addr  = mem_bus.mem_addr;
                end
            end else begin
                chk("idle_mem_req", mem_bus.mem_req, 0);
            end
            // memory responder
            rdy = 1'b0;
            rd  = 32'd0;
            if (m_state == M_IF || m_state == M_D) begin
                if (wait_cnt == 0) begin
                    rdy = 1'b1;
                    rd  = fixed_en ? fixed_val : $urandom();
                end else begin
                    wait_cnt--;
                end
            end
            mem_bus.mem_ready = rdy;
            mem_bus.mem_rdata = rd;
            #1;
            chk("if_ack", if_ack, (m_state == M_IF) && rdy);
            chk("d_ack", d_ack, ((m_state == M_D) && rdy) || (m_state == M_ERR));
            if (m_state == M_IF && rdy) begin
                chk("if_rdata", if_rdata, rd);
                if_rdata_log.push_back(if_rdata);
                if_pend = 1'b0;
            end
            if (m_state == M_D && rdy) begin
                chk("d_err_clear", d_err, 0);
                if (!cur_d.we) begin
                    chk("d_rdata", d_rdata, exp_load(rd, cur_d));
                    d_rdata_log.push_back(d_rdata);
                end
                d_pend = 1'b0;
            end
            if (m_state == M_ERR) begin
                chk("d_err", d_err, 1);
                chk("err_rdata", d_rdata, 0);
                d_pend = 1'b0;
            end
            nxt = m_state;
            if (rdy || m_state == M_ERR) nxt = M_IDLE;
            // requesters present their next request right after completion
            if (!if_pend) begin
                if (fq.size() > 0) begin
                    cur_if  = fq.pop_front();
                    if_pend = 1'b1;
                    if_req  = 1'b1;
                    if_addr = cur_if;
                end else begin
                    if_req = 1'b0;
                end
            end
            if (!d_pend) begin
                if (dq.size() > 0) begin
                    cur_d      = dq.pop_front();
                    d_pend     = 1'b1;
                    d_req      = 1'b1;
                    d_we       = cur_d.we;
                    d_addr     = cur_d.addr;
                    d_wdata    = cur_d.wdata;
                    d_mask     = cur_d.mask;
                    d_sign_ext = cur_d.sign;
                end else begin
                    d_req = 1'b0;
                end
            end
            // arbitration decided at the coming edge
            if (m_state == M_IDLE) begin
                if (d_req && (streak_m < MAX_STREAK || !if_req)) begin
                    grant_log.push_back(1'b1);
                    streak_m = if_req ? streak_m + 1 : 0;
                    nxt      = is_misaligned(cur_d) ? M_ERR : M_D;
                    wait_cnt = (delay_knob >= 0) ? delay_knob : $urandom_range(0, 3);
                end else if (if_req) begin
                    grant_log.push_back(1'b0);
                    streak_m = 0;
                    nxt      = M_IF;
                    wait_cnt = (delay_knob >= 0) ? delay_knob : $urandom_range(0, 3);
                end
            end
            m_state = nxt;
            done = (fq.size() == 0) && (dq.size() == 0) && !if_pend && !d_pend && (nxt == M_IDLE);
        end
        chk("traffic_drained", done, 1);
    endtask

    function automatic dreq_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input memory_mask_t mask, input logic sign);
        dreq_t r;
        r.we = we; r.addr = addr; r.wdata = wdata; r.mask = mask; r.sign = sign;
        return r;
    endfunction

    initial begin
        logic [9:0]  order;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 32'd0;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_mem_req", mem_bus.mem_req, 0);
        chk("rst_mem_we", mem_bus.mem_we, 0);
        chk("rst_mem_addr", mem_bus.mem_addr, 0);
        chk("rst_mem_be", mem_bus.mem_be, 0);
        chk("rst_mem_wdata", mem_bus.mem_wdata, 0);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_d_err", d_err, 0);
        rst = 1'b0;

        // fetch only, memory answers two cycles after the request
        delay_knob = 2; fixed_en = 1'b1; fixed_val = 32'h0050_0093;
        fq.push_back(32'h0000_0100);
        run_traffic(50);
        chk("fetch_rdata", if_rdata_log[$], 32'h0050_0093);

        // byte store to the top lane
        delay_knob = 1;
        dq.push_back(mk(1'b1, 32'h0000_0203, 32'h0000_00AB, MEM_BYTE, 1'b0));
        run_traffic(50);
        chk("sb_addr", last_st_addr, 32'h0000_0200);
        chk("sb_be", {28'd0, last_st_be}, 32'h8);
        chk("sb_wdata", last_st_wdata, 32'hABAB_ABAB);

        // loads from the word 0x80F0FF7F
        fixed_val = 32'h80F0_FF7F;
        d_rdata_log.delete();
        dq.push_back(mk(1'b0, 32'h0000_0300, 32'd0, MEM_BYTE, 1'b1));
        dq.push_back(mk(1'b0, 32'h0000_0302, 32'd0, MEM_BYTE, 1'b1));
        dq.push_back(mk(1'b0, 32'h0000_0302, 32'd0, MEM_HALFWORD, 1'b0));
        dq.push_back(mk(1'b0, 32'h0000_0302, 32'd0, MEM_HALFWORD, 1'b1));
        run_traffic(100);
        chk("lb0", d_rdata_log[0], 32'h0000_007F);
        chk("lb2", d_rdata_log[1], 32'hFFFF_FFF0);
        chk("lhu2", d_rdata_log[2], 32'h0000_80F0);
        chk("lh2", d_rdata_log[3], 32'hFFFF_80F0);

        // misaligned word load: error path, no bus activity
        dq.push_back(mk(1'b0, 32'h0000_0202, 32'd0, MEM_WORD, 1'b0));
        run_traffic(20);

        // both requesters busy: fetch gets one slot after four data grants
        delay_knob = 0; fixed_en = 1'b0;
        grant_log.delete();
        for (int i = 0; i < 10; i++) dq.push_back(mk(1'b0, 32'h1000 + 32'(4*i), 32'd0, MEM_WORD, 1'b0));
        fq.push_back(32'h0000_2000);
        fq.push_back(32'h0000_2004);
        run_traffic(200);
        order = 10'd0;
        for (int i = 0; i < 10; i++) order[9-i] = (i < grant_log.size()) ? grant_log[i] : 1'b0;
        chk("grant_order", {22'd0, order}, 32'b11110_11110);

        // random mixed traffic
        delay_knob = -1;
        for (int i = 0; i < 150; i++)
            dq.push_back(mk(1'($urandom_range(0, 1)), $urandom(), $urandom(),
                            memory_mask_t'(2'($urandom_range(0, 2))), 1'($urandom_range(0, 1))));
        for (int i = 0; i < 60; i++) fq.push_back($urandom());
        run_traffic(5000);

        // reset in the middle of a fetch abandons it
        @(negedge clk);
        mem_bus.mem_ready = 1'b0;
        if_req = 1'b1; if_addr = 32'h0000_0400;
        @(negedge clk);
        chk("abort_req_up", mem_bus.mem_req, 1);
        rst = 1'b1; if_req = 1'b0;
        @(negedge clk);
        chk("abort_req_drop", mem_bus.mem_req, 0);
        rst = 1'b0;
        mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h1234_5678;
        #1;
        chk("abort_if_ack", if_ack, 0);
        chk("abort_d_ack", d_ack, 0);
        @(negedge clk);
        mem_bus.mem_ready = 1'b0;
        #1;
        chk("abort_if_ack2", if_ack, 0);
        chk("abort_mem_req2", mem_bus.mem_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
